// File: rtl/fpnew_slice_result_arbiter.sv
// -----------------------------------------------------------------------------
// fpnew_slice_result_arbiter
//
// Collects results from the format slices of an operation group, picks one
// per cycle with a round-robin arbiter and registers the winner into a
// single-entry output stage. The output stage talks to the FPU-level output
// arbiter through its own valid/ready handshake.
//
// Parameters
//   NumInputs : number of slices feeding the arbiter (>= 1)
//   Width     : result width in bits
//   TagType   : operation tag type, passed through unchanged
//   IdxWidth  : derived width of src_idx_o (not meant to be overridden)
//
// Ports
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   slice_result_i     : per-slice result
//   slice_status_i     : per-slice exception flags
//   slice_ext_bit_i    : per-slice extension (NaN-box / sign) bit
//   slice_tag_i        : per-slice operation tag
//   slice_valid_i      : per-slice result valid
//   slice_ready_o      : per-slice ready, at most one bit set
//   flush_i            : synchronous kill of the buffered entry
//   result_o, status_o,
//   extension_bit_o,
//   tag_o              : registered winning entry
//   src_idx_o          : slice index that produced the buffered entry
//   out_valid_o        : buffered entry valid
//   out_ready_i        : downstream ready
//   busy_o             : entry buffered or any slice presenting a result
// -----------------------------------------------------------------------------

package fpnew_slice_result_arbiter_pkg;

    // IEEE 754 exception flags, same ordering as the fflags CSR.
    typedef struct packed {
        logic nv;  // invalid operation
        logic dz;  // divide by zero
        logic of;  // overflow
        logic uf;  // underflow
        logic nx;  // inexact
    } status_t;

endpackage

module fpnew_slice_result_arbiter
    import fpnew_slice_result_arbiter_pkg::*;
#(
    parameter int unsigned NumInputs = 4,
    parameter int unsigned Width     = 64,
    parameter type         TagType   = logic,
    localparam int unsigned IdxWidth = (NumInputs > 1) ? $clog2(NumInputs) : 1
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    // Slice side
    input  logic [NumInputs-1:0][Width-1:0]     slice_result_i,
    input  status_t [NumInputs-1:0]             slice_status_i,
    input  logic [NumInputs-1:0]                slice_ext_bit_i,
    input  TagType [NumInputs-1:0]              slice_tag_i,
    input  logic [NumInputs-1:0]                slice_valid_i,
    output logic [NumInputs-1:0]                slice_ready_o,
    // Control
    input  logic                                flush_i,
    // Output side
    output logic [Width-1:0]                    result_o,
    output status_t                             status_o,
    output logic                                extension_bit_o,
    output TagType                              tag_o,
    output logic [IdxWidth-1:0]                 src_idx_o,
    output logic                                out_valid_o,
    input  logic                                out_ready_i,
    output logic                                busy_o
);

    // -------------------------------------------------------------------------
    // Internal signals
    // -------------------------------------------------------------------------
    logic [IdxWidth-1:0] rr_q;      // first index searched this cycle
    logic [IdxWidth-1:0] winner;    // first valid slice at or after rr_q
    logic                found;     // at least one slice is valid
    logic                en;        // output stage can take a new entry
    logic                transfer;  // winner is moved into the output stage

    // The stage can load when it is empty or being drained this cycle.
    // A flush blocks any load so the killed slot stays empty for one cycle.
    assign en       = (~out_valid_o | out_ready_i) & ~flush_i;
    assign transfer = found & en;

    // -------------------------------------------------------------------------
    // Round-robin search: scan ascending from rr_q, wrapping at NumInputs-1.
    // -------------------------------------------------------------------------
    always_comb begin : arbitrate
        int unsigned idx;
        // NOTE: every variable written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        idx    = 0;
        winner = '0;
        found  = 1'b0;
        for (int unsigned k = 0; k < NumInputs; k++) begin
            idx = 32'(rr_q) + k;
            if (idx >= NumInputs) begin
                idx = idx - NumInputs;
            end
            if (!found && slice_valid_i[idx[IdxWidth-1:0]]) begin
                found  = 1'b1;
                winner = idx[IdxWidth-1:0];
            end
        end
    end

    // Only the winner sees ready, and only when the stage can take it.
    always_comb begin : grant
        slice_ready_o         = '0;
        slice_ready_o[winner] = transfer;
    end

    // -------------------------------------------------------------------------
    // Round-robin pointer: moves just past the winner on every transfer.
    // With a single slice there is nothing to rotate.
    // -------------------------------------------------------------------------
    if (NumInputs > 1) begin : gen_rr
        logic [IdxWidth-1:0] rr_d;

        always_comb begin : rr_next
            rr_d = rr_q;
            if (transfer) begin
                rr_d = (32'(winner) == NumInputs - 1) ? '0 : winner + 1'b1;
            end
        end

        // NOTE: sequential state is written with non-blocking assignments so
        // every register samples its inputs from before the clock edge.
        always_ff @(posedge clk_i or negedge rst_ni) begin : rr_reg
            if (!rst_ni) begin
                rr_q <= '0;
            end else begin
                rr_q <= rr_d;
            end
        end
    end else begin : gen_rr_const
        assign rr_q = '0;
    end

    // -------------------------------------------------------------------------
    // Output stage valid. A flush wins over both a drain and a new load.
    // When enabled, the slot is full next cycle exactly when a transfer
    // happens; otherwise (stalled) it keeps its current state.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin : valid_reg
        if (!rst_ni) begin
            out_valid_o <= 1'b0;
        end else if (flush_i) begin
            out_valid_o <= 1'b0;
        end else if (en) begin
            out_valid_o <= transfer;
        end
    end

    // -------------------------------------------------------------------------
    // Output stage payload. Loads only on a transfer, so it stays bit-stable
    // while stalled and keeps its last value once drained.
    // -------------------------------------------------------------------------
    // NOTE: the payload is reset as well, so downstream sees all-zero outputs
    // after reset instead of X; this is a single entry, not a memory array.
    always_ff @(posedge clk_i or negedge rst_ni) begin : data_reg
        if (!rst_ni) begin
            result_o        <= '0;
            status_o        <= '0;
            extension_bit_o <= 1'b0;
            tag_o           <= '0;
            src_idx_o       <= '0;
        end else if (transfer) begin
            result_o        <= slice_result_i[winner];
            status_o        <= slice_status_i[winner];
            extension_bit_o <= slice_ext_bit_i[winner];
            tag_o           <= slice_tag_i[winner];
            src_idx_o       <= winner;
        end
    end

    assign busy_o = out_valid_o | (|slice_valid_i);

    // -------------------------------------------------------------------------
    // Protocol properties
    // -------------------------------------------------------------------------
    ready_onehot0 : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        $onehot0(slice_ready_o)
    );

    stall_stable : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (out_valid_o && !out_ready_i && !flush_i)
        |=> (out_valid_o && $stable(result_o) && $stable(status_o) &&
             $stable(extension_bit_o) && $stable(tag_o) && $stable(src_idx_o))
    );

endmodule

// File: tb/tb_fpnew_slice_result_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for fpnew_slice_result_arbiter (NumInputs=4, Width=64, 8-bit tag).
// Stimulus pushes the expected entry into a scoreboard queue whenever it
// presents a slice that must be accepted; a monitor on the falling edge pops
// and compares each entry as it leaves the output stage (handshake or flush).
// Same-cycle grant, stall and reset behaviour is checked directly.
// -----------------------------------------------------------------------------
module tb_fpnew_slice_result_arbiter;

    localparam int N = 4;
    localparam int W = 64;
    typedef logic [7:0] tag_t;

    typedef struct {
        logic [W-1:0] res;
        logic [4:0]   st;
        logic         ext;
        tag_t         tag;
        logic [1:0]   idx;
    } entry_t;

    logic                clk_i = 1'b0;
    logic                rst_ni = 1'b0;
    logic [N-1:0][W-1:0] slice_result;
    logic [N-1:0][4:0]   slice_status;
    logic [N-1:0]        slice_ext_bit;
    tag_t [N-1:0]        slice_tag;
    logic [N-1:0]        slice_valid;
    logic [N-1:0]        slice_ready;
    logic                flush;
    logic [W-1:0]        result;
    logic [4:0]          status;
    logic                ext_bit;
    tag_t                tag;
    logic [1:0]          src_idx;
    logic                out_valid;
    logic                out_ready;
    logic                busy;

    int     checks = 0;
    int     errors = 0;
    entry_t sb[$];

    fpnew_slice_result_arbiter #(
        .NumInputs (N),
        .Width     (W),
        .TagType   (tag_t)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .slice_result_i  (slice_result),
        .slice_status_i  (slice_status),
        .slice_ext_bit_i (slice_ext_bit),
        .slice_tag_i     (slice_tag),
        .slice_valid_i   (slice_valid),
        .slice_ready_o   (slice_ready),
        .flush_i         (flush),
        .result_o        (result),
        .status_o        (status),
        .extension_bit_o (ext_bit),
        .tag_o           (tag),
        .src_idx_o       (src_idx),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .busy_o          (busy)
    );

    always #5 clk_i = ~clk_i;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_slice(input int i, input logic [W-1:0] r, input logic [4:0] s,
                             input logic e, input tag_t t);
        slice_result[i]  = r;
        slice_status[i]  = s;
        slice_ext_bit[i] = e;
        slice_tag[i]     = t;
        slice_valid[i]   = 1'b1;
    endtask

    // Slice i is known (by hand) to win this cycle: record what it presents.
    task automatic expect_slice(input int i);
        entry_t e;
        e.res = slice_result[i];
        e.st  = slice_status[i];
        e.ext = slice_ext_bit[i];
        e.tag = slice_tag[i];
        e.idx = 2'(i);
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        slice_valid = '0;
        out_ready   = 1'b1;
        flush       = 1'b0;
        repeat (n) step();
    endtask

    // -------------------------------------------------------------------------
    // Monitor: an entry leaves on a handshake or is killed by a flush.
    // -------------------------------------------------------------------------
    always @(negedge clk_i) begin
        if (rst_ni && out_valid && (out_ready || flush)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got result %h tag %h src %0d, expected no entry",
                         result, tag, src_idx);
            end else begin
                entry_t e;
                e = sb.pop_front();
                check("sb_result", result, e.res);
                check("sb_status", 64'(status), 64'(e.st));
                check("sb_ext", 64'(ext_bit), 64'(e.ext));
                check("sb_tag", 64'(tag), 64'(e.tag));
                check("sb_src_idx", 64'(src_idx), 64'(e.idx));
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    localparam int Grants[5] = '{0, 1, 2, 3, 0};

    initial begin
        slice_result  = '0;
        slice_status  = '0;
        slice_ext_bit = '0;
        slice_tag     = '0;
        slice_valid   = '0;
        flush         = 1'b0;
        out_ready     = 1'b0;

        // Reset state
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_src_idx", 64'(src_idx), 64'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // Test 1: slice 2 alone, one-cycle latency; rr moves to 3
        out_ready = 1'b1;
        set_slice(2, 64'h3FF0_0000_0000_0000, 5'b00001, 1'b1, 8'd7);
        #1;
        check("t1_ready", 64'(slice_ready), 64'b0100);
        check("t1_busy", 64'(busy), 64'd1);
        expect_slice(2);
        step();
        slice_valid = '0;
        #1;
        check("t1_out_valid", 64'(out_valid), 64'd1);
        check("t1_src_idx", 64'(src_idx), 64'd2);
        step();
        check("t1_drained", 64'(out_valid), 64'd0);

        // Test 5: rr=3, slices 0 and 1 valid -> 0 wins by wrapping, then 1
        set_slice(0, 64'h4000_0000_0000_0000, 5'b00010, 1'b0, 8'h50);
        set_slice(1, 64'h4008_0000_0000_0000, 5'b00100, 1'b1, 8'h51);
        #1;
        check("t5_wrap_ready", 64'(slice_ready), 64'b0001);
        expect_slice(0);
        step();
        set_slice(0, 64'h4010_0000_0000_0000, 5'b01000, 1'b0, 8'h52);
        #1;
        check("t5_next_ready", 64'(slice_ready), 64'b0010);
        expect_slice(1);
        step();
        slice_valid = '0;
        // rr is now 2; slice 3 alone brings it back to 0
        set_slice(3, 64'h7FF8_0000_0000_0000, 5'b10000, 1'b1, 8'h33);
        #1;
        check("t5_slice3_ready", 64'(slice_ready), 64'b1000);
        expect_slice(3);
        step();
        idle(2);

        // Test 2: all four valid, rr=0 -> grants 0,1,2,3,0
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < N; i++) begin
                set_slice(i, 64'hA000_0000_0000_0000 + 64'(c * 16 + i), 5'(c + i),
                          1'(c), 8'(8'h20 + c * 4 + i));
            end
            #1;
            check("t2_ready", 64'(slice_ready), 64'(4'b0001 << Grants[c]));
            expect_slice(Grants[c]);
            step();
            if (c > 0) check("t2_src_idx", 64'(src_idx), 64'(Grants[c]));
        end
        idle(2);

        // Test 3: rr=1; load slice 2 with downstream stalled, then hold 5 cycles
        out_ready = 1'b0;
        set_slice(2, 64'h1234_5678_9ABC_DEF0, 5'b00011, 1'b1, 8'd9);
        #1;
        check("t3_load_ready", 64'(slice_ready), 64'b0100);
        expect_slice(2);
        step();
        slice_valid = '0;
        set_slice(1, 64'hBFF0_0000_0000_0000, 5'b00101, 1'b0, 8'h61);
        set_slice(3, 64'hC000_0000_0000_0000, 5'b00110, 1'b1, 8'h63);
        for (int k = 0; k < 5; k++) begin
            #1;
            check("t3_stall_ready", 64'(slice_ready), 64'd0);
            check("t3_stall_valid", 64'(out_valid), 64'd1);
            check("t3_stall_result", result, 64'h1234_5678_9ABC_DEF0);
            check("t3_stall_tag", 64'(tag), 64'd9);
            check("t3_stall_src", 64'(src_idx), 64'd2);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("t3_release_ready", 64'(slice_ready), 64'b1000);
        expect_slice(3);
        step();
        check("t3_back_to_back_valid", 64'(out_valid), 64'd1);
        slice_valid[3] = 1'b0;
        #1;
        check("t3_second_ready", 64'(slice_ready), 64'b0010);
        expect_slice(1);
        step();
        idle(2);

        // Test 4: rr=2; hold an entry with tag 5, then flush it
        out_ready = 1'b0;
        set_slice(0, 64'h5555_0000_0000_0005, 5'b01001, 1'b0, 8'd5);
        #1;
        check("t4_load_ready", 64'(slice_ready), 64'b0001);
        expect_slice(0);
        step();
        set_slice(0, 64'h6666_0000_0000_0006, 5'b01010, 1'b1, 8'd6);
        flush     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("t4_flush_ready", 64'(slice_ready), 64'd0);
        step();
        flush = 1'b0;
        #1;
        check("t4_flushed_valid", 64'(out_valid), 64'd0);
        check("t4_after_ready", 64'(slice_ready), 64'b0001);
        expect_slice(0);
        step();
        check("t4_reload_valid", 64'(out_valid), 64'd1);
        check("t4_reload_tag", 64'(tag), 64'd6);
        idle(2);

        // Test 6: asynchronous reset mid-cycle drops a held entry
        out_ready = 1'b0;
        set_slice(1, 64'hDEAD_BEEF_0000_0001, 5'b11111, 1'b1, 8'hEE);
        step();
        slice_valid = '0;
        #1;
        check("t6_held_valid", 64'(out_valid), 64'd1);
        #2 rst_ni = 1'b0;
        #1;
        check("t6_rst_valid", 64'(out_valid), 64'd0);
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_result", result, 64'd0);
        check("t6_rst_status", 64'(status), 64'd0);
        check("t6_rst_ext", 64'(ext_bit), 64'd0);
        check("t6_rst_tag", 64'(tag), 64'd0);
        check("t6_rst_src", 64'(src_idx), 64'd0);
        check("t6_rst_ready", 64'(slice_ready), 64'd0);
        #3 rst_ni = 1'b1;
        out_ready = 1'b1;
        step();
        check("t6_post_valid", 64'(out_valid), 64'd0);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
